// File: rtl/hex_speed_display.sv
// hex_speed_display: drives six active-low seven-segment digits from the
// HPS hex PIO word and a ten-LED bar graph with peak-hold/decay marker from
// the HPS speed PIO word.
module hex_speed_display #(
    parameter int unsigned HOLD_CYCLES  = 25_000_000,
    parameter int unsigned DECAY_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] hex_value,
    input  logic [9:0]  speed,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [9:0]  ledr
);

    localparam int unsigned HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
    localparam int unsigned DW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

    typedef enum logic [1:0] {
        TRACK,
        HOLD,
        DECAY
    } state_t;

    logic [31:0]       hex_r;
    logic [9:0]        speed_r;
    logic [3:0]        level_r;
    logic [5:0][6:0]   digit_nxt;
    logic              zero_run;
    logic [9:0]        bar;
    logic [9:0]        led_nxt;

    state_t            state, state_nxt;
    logic [3:0]        peak, peak_nxt;
    logic [HW-1:0]     hold_cnt, hold_nxt;
    logic [DW-1:0]     decay_cnt, decay_nxt;

    // bit 30 of the PIO word carries nothing
    logic unused_hex_bit;
    assign unused_hex_bit = hex_r[30];

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Input stage: capture the PIO words every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_r   <= '0;
            speed_r <= '0;
            level_r <= '0;
        end else begin
            hex_r   <= hex_value;
            speed_r <= speed;
            level_r <= 4'((14'(speed_r) * 14'd11) >> 10);
        end
    end

    // Digit decode with blanking; walk from digit 5 down so zero_run tells
    // whether this digit and every digit above it are zero
    always_comb begin
        digit_nxt = '1;
        zero_run  = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            zero_run = zero_run & (hex_r[4*(5-k) +: 4] == 4'h0);
            if (hex_r[24 + 5 - k])
                digit_nxt[5-k] = 7'h7F;
            else if (hex_r[31] && (k != 5) && zero_run)
                digit_nxt[5-k] = 7'h7F;
            else
                digit_nxt[5-k] = seg7(hex_r[4*(5-k) +: 4]);
        end
    end

    // Segment output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex0 <= 7'h7F;
            hex1 <= 7'h7F;
            hex2 <= 7'h7F;
            hex3 <= 7'h7F;
            hex4 <= 7'h7F;
            hex5 <= 7'h7F;
        end else begin
            hex0 <= digit_nxt[0];
            hex1 <= digit_nxt[1];
            hex2 <= digit_nxt[2];
            hex3 <= digit_nxt[3];
            hex4 <= digit_nxt[4];
            hex5 <= digit_nxt[5];
        end
    end

    // Bar graph: LEDs below the current level are lit
    always_comb begin
        bar = '0;
        for (int unsigned k = 0; k < 10; k++)
            bar[k] = (4'(k) < level_r);
    end

    // Peak tracker next state; a level at or above the peak always wins,
    // even over a decrement falling due on the same edge
    always_comb begin
        state_nxt = state;
        peak_nxt  = peak;
        hold_nxt  = hold_cnt;
        decay_nxt = decay_cnt;
        if (level_r >= peak) begin
            peak_nxt  = level_r;
            hold_nxt  = '0;
            state_nxt = HOLD;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        state_nxt = DECAY;
                        decay_nxt = '0;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end
                DECAY: begin
                    if (decay_cnt == DW'(DECAY_CYCLES - 1)) begin
                        peak_nxt  = peak - 4'd1;
                        decay_nxt = '0;
                        if ((peak - 4'd1) <= level_r)
                            state_nxt = TRACK;
                    end else begin
                        decay_nxt = decay_cnt + DW'(1);
                    end
                end
                default: peak_nxt = level_r;
            endcase
        end
        led_nxt = bar | ((peak_nxt != 4'd0) ? (10'd1 << (peak_nxt - 4'd1)) : 10'd0);
    end

    // Peak FSM, counters and LED register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= TRACK;
            peak      <= '0;
            hold_cnt  <= '0;
            decay_cnt <= '0;
            ledr      <= '0;
        end else begin
            state     <= state_nxt;
            peak      <= peak_nxt;
            hold_cnt  <= hold_nxt;
            decay_cnt <= decay_nxt;
            ledr      <= led_nxt;
        end
    end

endmodule

// File: tb/tb_hex_speed_display.sv
// Directed bench for hex_speed_display with short hold/decay windows.
module tb_hex_speed_display;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] hex_value;
    logic [9:0]  speed;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0]  ledr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        bit          is_hex;
        logic [41:0] val;
    } exp_t;

    exp_t sb[$];

    hex_speed_display #(
        .HOLD_CYCLES (4),
        .DECAY_CYCLES(3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .hex_value(hex_value),
        .speed    (speed),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5),
        .ledr     (ledr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_hex(input string tag, input logic [41:0] v);
        sb.push_back('{tag, 1'b1, v});
    endtask

    task automatic exp_led(input string tag, input logic [9:0] v);
        sb.push_back('{tag, 1'b0, {32'b0, v}});
    endtask

    task automatic check_one();
        exp_t e;
        logic [41:0] obs;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed=nothing expected=entry");
        end else begin
            e   = sb.pop_front();
            obs = e.is_hex ? {hex5, hex4, hex3, hex2, hex1, hex0} : {32'b0, ledr};
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        logic [9:0] lv_speed [5];
        logic [9:0] lv_led   [5];
        logic [9:0] prev_led;
        logic [9:0] e_led;

        lv_speed = '{10'd93, 10'd94, 10'd186, 10'd187, 10'd1023};
        lv_led   = '{10'h000, 10'h001, 10'h001, 10'h003, 10'h3FF};

        reset_n   = 1'b0;
        hex_value = 32'h0;
        speed     = 10'd0;
        tick(2);
        exp_hex("rst_hex", {6{7'h7F}});
        check_one();
        exp_led("rst_led", 10'h000);
        check_one();
        reset_n = 1'b1;
        tick(2);

        // hex path
        hex_value = 32'h00ABCDEF;
        exp_hex("hex_abcdef", {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});
        tick(2);
        check_one();

        hex_value = 32'h80000050;
        exp_hex("hex_latency_old", {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});
        tick(1);
        check_one();
        exp_hex("hex_lz_50", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40});
        tick(1);
        check_one();

        hex_value = 32'h80000000;
        exp_hex("hex_lz_zero", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        tick(2);
        check_one();

        hex_value = 32'h80000F00;
        exp_hex("hex_lz_inner0", {7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40});
        tick(2);
        check_one();

        hex_value = 32'h3F123456;
        exp_hex("hex_blank_all", {6{7'h7F}});
        tick(2);
        check_one();

        hex_value = 32'h01123456;
        exp_hex("hex_blank_d0", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h7F});
        tick(2);
        check_one();

        // level boundaries, ascending so the marker stays inside the bar
        prev_led = 10'h000;
        for (int i = 0; i < 5; i++) begin
            speed = lv_speed[i];
            exp_led($sformatf("lvl_old_%0d", lv_speed[i]), prev_led);
            tick(2);
            check_one();
            exp_led($sformatf("lvl_%0d", lv_speed[i]), lv_led[i]);
            tick(1);
            check_one();
            prev_led = lv_led[i];
        end

        speed = 10'd512;
        exp_led("lvl_512_peak10", 10'h21F);
        tick(3);
        check_one();

        // full decay from 10
        speed = 10'd1023;
        exp_led("full_bar", 10'h3FF);
        tick(3);
        check_one();
        tick(2);
        speed = 10'd0;
        exp_led("drop_pipe", 10'h3FF);
        tick(2);
        check_one();
        exp_led("hold_start", 10'h200);
        tick(1);
        check_one();
        exp_led("hold_end", 10'h200);
        tick(5);
        check_one();
        exp_led("decay_1", 10'h100);
        tick(1);
        check_one();
        for (int k = 2; k <= 10; k++) begin
            e_led = (k == 10) ? 10'h000 : (10'd1 << (9 - k));
            exp_led($sformatf("decay_%0d", k), e_led);
            tick(3);
            check_one();
        end
        tick(2);

        // rise during decay restarts the hold at the new peak
        speed = 10'd1023;
        tick(5);
        speed = 10'd0;
        exp_led("mid_peak6", 10'h020);
        tick(18);
        check_one();
        speed = 10'd720;
        exp_led("mid_rise_pipe", 10'h020);
        tick(2);
        check_one();
        exp_led("mid_rise_7", 10'h07F);
        tick(1);
        check_one();
        speed = 10'd0;
        exp_led("rehold_pipe", 10'h07F);
        tick(2);
        check_one();
        exp_led("rehold_start", 10'h040);
        tick(1);
        check_one();
        exp_led("rehold_end", 10'h040);
        tick(5);
        check_one();
        exp_led("rehold_decay", 10'h020);
        tick(1);
        check_one();

        // asynchronous reset mid-decay, no clock edge in between
        reset_n = 1'b0;
        #1;
        exp_hex("async_rst_hex", {6{7'h7F}});
        check_one();
        exp_led("async_rst_led", 10'h000);
        check_one();
        tick(1);
        reset_n = 1'b1;
        exp_hex("post_rst_hex", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h7F});
        tick(2);
        check_one();
        exp_led("post_rst_led", 10'h000);
        tick(1);
        check_one();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_leftover: observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
